// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-unit bus: pipeline observations in, pipeline controls and perf counters out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic [4:0]       EX_rd;
  logic             EX_mem_read;
  logic             EX_branch_taken;
  logic             dmem_busy;
  logic             clr_err;

  logic             PC_write;
  logic             pc_sel;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EX_bubble;
  logic             freeze;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] freeze_cnt;

  // Pipeline side: drives the hazard observations, consumes the controls.
  modport master (
    output ID_rs1, ID_rs2, EX_rd, EX_mem_read, EX_branch_taken, dmem_busy, clr_err,
    input  PC_write, pc_sel, IF_ID_write, IF_ID_flush, ID_EX_bubble, freeze,
           timeout_err, stall_cnt, flush_cnt, freeze_cnt
  );

  // Hazard unit side.
  modport slave (
    input  ID_rs1, ID_rs2, EX_rd, EX_mem_read, EX_branch_taken, dmem_busy, clr_err,
    output PC_write, pc_sel, IF_ID_write, IF_ID_flush, ID_EX_bubble, freeze,
           timeout_err, stall_cnt, flush_cnt, freeze_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: memory-wait freeze, taken-branch flush,
// load-use stall, wait timeout flag and saturating performance counters.
module pipe_hazard_ctrl #(
  parameter int WAIT_TIMEOUT = 255,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  hz_if
);

  typedef enum logic [1:0] {RUN, FREEZE, DRAIN} state_e;

  localparam logic [15:0]      TMO     = 16'(WAIT_TIMEOUT);
  localparam logic [15:0]      WAIT_MX = 16'hFFFF;
  localparam logic [CNT_W-1:0] CNT_MX  = '1;

  state_e           state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] frz_q, frz_d;

  logic load_use, brk, frozen, do_flush, do_stall;

  // Hazard terms; x0 is never a real dependency. Freeze covers the first busy
  // cycle in RUN/DRAIN as well as every FREEZE cycle, and beats everything else.
  always_comb begin
    load_use = hz_if.EX_mem_read && (hz_if.EX_rd != 5'd0) &&
               ((hz_if.EX_rd == hz_if.ID_rs1) || (hz_if.EX_rd == hz_if.ID_rs2));
    brk      = hz_if.EX_branch_taken;
    frozen   = !reset && ((state_q == FREEZE) || hz_if.dmem_busy);
    do_flush = !reset && !frozen && brk;
    do_stall = !reset && !frozen && !brk && load_use;
  end

  // Next state: DRAIN is a RUN cycle that can fall straight back into FREEZE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (hz_if.dmem_busy) state_d = FREEZE;
      FREEZE:  if (!hz_if.dmem_busy) state_d = DRAIN;
      DRAIN:   state_d = hz_if.dmem_busy ? FREEZE : RUN;
      default: state_d = RUN;
    endcase
  end

  // Mealy pipeline controls; all deasserted while reset is held.
  always_comb begin
    hz_if.PC_write     = 1'b0;
    hz_if.pc_sel       = 1'b0;
    hz_if.IF_ID_write  = 1'b0;
    hz_if.IF_ID_flush  = 1'b0;
    hz_if.ID_EX_bubble = 1'b0;
    hz_if.freeze       = 1'b0;
    if (frozen) begin
      hz_if.freeze = 1'b1;
    end else if (do_flush) begin
      hz_if.PC_write     = 1'b1;
      hz_if.pc_sel       = 1'b1;
      hz_if.IF_ID_write  = 1'b1;
      hz_if.IF_ID_flush  = 1'b1;
      hz_if.ID_EX_bubble = 1'b1;
    end else if (do_stall) begin
      hz_if.ID_EX_bubble = 1'b1;
    end else if (!reset) begin
      hz_if.PC_write    = 1'b1;
      hz_if.IF_ID_write = 1'b1;
    end
  end

  // Wait counter, sticky timeout (set wins over clear) and perf counters.
  always_comb begin
    wait_d  = (state_q == FREEZE) ? ((wait_q == WAIT_MX) ? wait_q : wait_q + 16'd1) : 16'd0;
    err_d   = ((state_q == FREEZE) && (wait_d == TMO)) ? 1'b1 :
              (hz_if.clr_err ? 1'b0 : err_q);
    stall_d = (do_stall && stall_q != CNT_MX) ? stall_q + CNT_W'(1) : stall_q;
    flush_d = (do_flush && flush_q != CNT_MX) ? flush_q + CNT_W'(1) : flush_q;
    frz_d   = (frozen   && frz_q   != CNT_MX) ? frz_q   + CNT_W'(1) : frz_q;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= 16'd0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
      frz_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      frz_q   <= frz_d;
    end
  end

  assign hz_if.timeout_err = err_q;
  assign hz_if.stall_cnt   = stall_q;
  assign hz_if.flush_cnt   = flush_q;
  assign hz_if.freeze_cnt  = frz_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: rule-level model checked every cycle plus
// hand-computed literal expectations for the directed scenarios.
module tb_pipe_hazard_ctrl;
  localparam int T    = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) hz_if();
  pipe_hazard_ctrl #(.WAIT_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz_if (hz_if.slave)
  );

  int checks = 0;
  int failures = 0;

  // Model: previous-cycle busy means the unit is waiting on memory this cycle;
  // m_run is the length of the busy run that ended last cycle.
  int m_stall = 0, m_flush = 0, m_freeze = 0, m_run = 0;
  bit m_err = 0, m_pb = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {PC_write, pc_sel, IF_ID_write, IF_ID_flush, ID_EX_bubble, freeze}
  function automatic logic [5:0] exp_ctrl();
    logic lu;
    if (reset) return 6'b000000;
    if (hz_if.dmem_busy || m_pb) return 6'b000001;
    if (hz_if.EX_branch_taken) return 6'b111110;
    lu = hz_if.EX_mem_read && hz_if.EX_rd != 5'd0 &&
         (hz_if.EX_rd == hz_if.ID_rs1 || hz_if.EX_rd == hz_if.ID_rs2);
    if (lu) return 6'b000010;
    return 6'b101000;
  endfunction

  function automatic logic [5:0] act_ctrl();
    return {hz_if.PC_write, hz_if.pc_sel, hz_if.IF_ID_write,
            hz_if.IF_ID_flush, hz_if.ID_EX_bubble, hz_if.freeze};
  endfunction

  // Compare at negedge, advance model at posedge.
  initial begin
    logic [5:0] e;
    bit set;
    forever begin
      @(negedge clk);
      chk("ctrl", 32'(act_ctrl()), 32'(exp_ctrl()));
      chk("stall_cnt", 32'(hz_if.stall_cnt), reset ? 0 : m_stall);
      chk("flush_cnt", 32'(hz_if.flush_cnt), reset ? 0 : m_flush);
      chk("freeze_cnt", 32'(hz_if.freeze_cnt), reset ? 0 : m_freeze);
      chk("timeout_err", 32'(hz_if.timeout_err), reset ? 0 : 32'(m_err));
      @(posedge clk);
      if (reset) begin
        m_stall = 0; m_flush = 0; m_freeze = 0; m_run = 0; m_err = 0; m_pb = 0;
      end else begin
        e = exp_ctrl();
        if (e == 6'b000010 && m_stall < CMAX) m_stall++;
        if (e == 6'b111110 && m_flush < CMAX) m_flush++;
        if (e[0] && m_freeze < CMAX) m_freeze++;
        set   = m_pb && (m_run == T);
        m_err = set || (m_err && !hz_if.clr_err);
        m_run = hz_if.dmem_busy ? m_run + 1 : 0;
        m_pb  = hz_if.dmem_busy;
      end
    end
  end

  task automatic drive(input int rs1, input int rs2, input int rd,
                       input bit mr, input bit br, input bit busy, input bit clr);
    hz_if.ID_rs1          = 5'(rs1);
    hz_if.ID_rs2          = 5'(rs2);
    hz_if.EX_rd           = 5'(rd);
    hz_if.EX_mem_read     = mr;
    hz_if.EX_branch_taken = br;
    hz_if.dmem_busy       = busy;
    hz_if.clr_err         = clr;
  endtask

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); #1; endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;
  endtask

  // Mixed vectors: rs1, rs2, rd, mem_read, branch, busy
  int vec [10][6] = '{
    '{3, 4, 3, 1, 0, 0}, '{3, 4, 4, 0, 0, 0}, '{9, 9, 9, 1, 1, 0}, '{1, 2, 2, 1, 0, 1},
    '{1, 2, 2, 1, 0, 0}, '{1, 2, 2, 1, 0, 0}, '{0, 0, 0, 1, 0, 1}, '{5, 6, 6, 1, 1, 0},
    '{5, 6, 6, 1, 1, 1}, '{7, 8, 31, 1, 0, 0}};

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("rst_PC_write", 32'(hz_if.PC_write), 0);
    chk("rst_IF_ID_write", 32'(hz_if.IF_ID_write), 0);
    chk("rst_stall_cnt", 32'(hz_if.stall_cnt), 0);
    tick();
    reset = 1'b0;

    // Load-use on rs2
    drive(1, 5, 5, 1, 0, 0, 0);
    mid();
    chk("lu_PC_write", 32'(hz_if.PC_write), 0);
    chk("lu_IF_ID_write", 32'(hz_if.IF_ID_write), 0);
    chk("lu_bubble", 32'(hz_if.ID_EX_bubble), 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("lu_stall_cnt", 32'(hz_if.stall_cnt), 1);

    // x0 destination is never a hazard
    drive(0, 3, 0, 1, 0, 0, 0);
    mid();
    chk("x0_PC_write", 32'(hz_if.PC_write), 1);
    chk("x0_IF_ID_write", 32'(hz_if.IF_ID_write), 1);
    chk("x0_bubble", 32'(hz_if.ID_EX_bubble), 0);
    tick();

    // Branch beats load-use
    drive(7, 0, 7, 1, 1, 0, 0);
    mid();
    chk("br_ctrl", 32'(act_ctrl()), 32'(6'b111110));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("br_flush_cnt", 32'(hz_if.flush_cnt), 1);
    chk("br_stall_cnt", 32'(hz_if.stall_cnt), 1);

    // Branch held through a freeze is taken in the drain cycle
    do_reset();
    drive(0, 0, 0, 0, 1, 1, 0);
    mid();
    chk("hold_frz1", 32'(act_ctrl()), 32'(6'b000001));
    tick();
    drive(0, 0, 0, 0, 1, 1, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    mid();
    chk("hold_frz3", 32'(act_ctrl()), 32'(6'b000001));
    tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    mid();
    chk("drain_flush", 32'(act_ctrl()), 32'(6'b111110));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("hold_freeze_cnt", 32'(hz_if.freeze_cnt), 3);
    chk("hold_flush_cnt", 32'(hz_if.flush_cnt), 1);

    // Timeout after the 5th busy cycle, sticky, then cleared
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      tick();
      if (i == 4) chk("tmo_not_yet", 32'(hz_if.timeout_err), 0);
      if (i == 5) chk("tmo_set", 32'(hz_if.timeout_err), 1);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("tmo_sticky", 32'(hz_if.timeout_err), 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("tmo_clr", 32'(hz_if.timeout_err), 0);
    // Set and clear on the same edge: set wins
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 0, 0, 0, 1, 1);
      tick();
      if (i == 4) chk("tmo_clr_hold", 32'(hz_if.timeout_err), 0);
    end
    chk("tmo_set_wins", 32'(hz_if.timeout_err), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    // Mixed vectors, checked by the model only
    foreach (vec[i]) begin
      drive(vec[i][0], vec[i][1], vec[i][2], vec[i][3] != 0, vec[i][4] != 0, vec[i][5] != 0, 0);
      tick();
    end

    // Reset in the middle of a freeze
    drive(0, 0, 0, 0, 0, 1, 0);
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_ctrl", 32'(act_ctrl()), 0);
    chk("mid_rst_freeze_cnt", 32'(hz_if.freeze_cnt), 0);
    chk("mid_rst_err", 32'(hz_if.timeout_err), 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    mid();
    chk("post_rst_PC_write", 32'(hz_if.PC_write), 1);
    chk("post_rst_freeze", 32'(hz_if.freeze), 0);
    tick();

    // stall_cnt saturation
    do_reset();
    for (int i = 0; i < CMAX; i++) begin
      drive(2, 0, 2, 1, 0, 0, 0);
      tick();
    end
    chk("sat_full", 32'(hz_if.stall_cnt), 32'(CMAX));
    drive(2, 0, 2, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("sat_hold", 32'(hz_if.stall_cnt), 32'(CMAX));
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
